// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, mid-bit sampling, one-cycle valid/error strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned HALF         = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    idx, idx_next;
    logic [7:0]    shreg, shreg_next;
    logic [7:0]    data_next;
    logic          valid_next, frame_err_next, parity_err_next, busy_next;
    logic          rx_meta, rx_s;
    logic          mismatch_c;
    logic          bit_done_c;

`ifdef UART_RX_PARITY_EN
    logic          par, par_next;
    assign mismatch_c = (^shreg) ^ par;
`else
    assign mismatch_c = 1'b0;
`endif

    // Two-flop synchronizer; idle line is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            idx        <= idx_next;
            shreg      <= shreg_next;
            data       <= data_next;
            valid      <= valid_next;
            frame_err  <= frame_err_next;
            parity_err <= parity_err_next;
            busy       <= busy_next;
`ifdef UART_RX_PARITY_EN
            par        <= par_next;
`endif
        end
    end

    assign bit_done_c = (cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        idx_next        = idx;
        shreg_next      = shreg;
        data_next       = data;
        valid_next      = 1'b0;
        frame_err_next  = 1'b0;
        parity_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next        = par;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt == CW'(HALF - 1)) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_done_c) begin
                    cnt_next   = '0;
                    shreg_next = {rx_s, shreg[7:1]};
                    idx_next   = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_done_c) begin
                    cnt_next   = '0;
                    par_next   = rx_s;
                    state_next = STOP;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_done_c) begin
                    cnt_next        = '0;
                    data_next       = shreg;
                    parity_err_next = mismatch_c;
                    if (rx_s) begin
                        valid_next = !mismatch_c;
                        state_next = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            // Line held low after a bad stop bit: one frame_err per break
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT=16.
module tb_uart_rx;

    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int vcnt     = 0;
    int fcnt     = 0;
    int pcnt     = 0;
    int both_cnt = 0;
    int last_vcyc = 0;
    int start_cyc = 0;
    logic [7:0] vq[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output strobes observed on the falling edge
    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            vq.push_back(data);
            last_vcyc = cyc;
        end
        if (frame_err) fcnt++;
        if (parity_err) pcnt++;
        if (valid && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        start_cyc = cyc + 1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit);
`else
        if (par_bit) begin end
`endif
        send_bit(stop_bit);
    endtask

    initial begin
        int v0;
        int f0;
        int waited;
        reset = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_perr", 32'(parity_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        repeat (200) @(negedge clk);
        check("idle_vcnt", 32'(vcnt), 32'd0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_data", 32'(data), 32'h00);

        // Single frame with latency check
        send_frame(8'hA5, 1'b1, 1'b0);
        send_bit(1'b1);
        check("a5_vcnt", 32'(vcnt), 32'd1);
        check("a5_data", 32'(vq.pop_front()), 32'hA5);
        check("a5_latency", 32'(last_vcyc - start_cyc), 32'(2 + HALF + 9 * CPB));
        check("a5_ferr", 32'(fcnt), 32'd0);

        // Back-to-back frames, no idle between
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b0);
        send_bit(1'b1);
        check("b2b_vcnt", 32'(vcnt), 32'd4);
        check("b2b_0", 32'(vq.pop_front()), 32'h00);
        check("b2b_1", 32'(vq.pop_front()), 32'hFF);
        check("b2b_2", 32'(vq.pop_front()), 32'h3C);

        // Short glitch on idle line
        v0 = vcnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        waited = 0;
        while (busy !== 1'b0 && waited < int'(HALF + 3)) begin
            @(negedge clk);
            waited++;
        end
        check("glitch_busy_low", 32'(busy), 32'h0);
        repeat (20) @(negedge clk);
        check("glitch_vcnt", 32'(vcnt), 32'(v0));
        check("glitch_fcnt", 32'(fcnt), 32'd0);

        // Bad stop bit, then break held low
        v0 = vcnt;
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("ferr_cnt", 32'(fcnt), 32'd1);
        check("ferr_vcnt", 32'(vcnt), 32'(v0));
        check("ferr_data", 32'(data), 32'h55);
        send_frame(8'h12, 1'b1, 1'b0);
        send_bit(1'b1);
        check("after_ferr_vcnt", 32'(vcnt), 32'(v0 + 1));
        check("after_ferr_data", 32'(vq.pop_front()), 32'h12);

`ifdef UART_RX_PARITY_EN
        f0 = pcnt;
        v0 = vcnt;
        send_frame(8'h07, 1'b1, 1'b0);
        send_bit(1'b1);
        check("par_bad_perr", 32'(pcnt), 32'(f0 + 1));
        check("par_bad_vcnt", 32'(vcnt), 32'(v0));
        send_frame(8'h07, 1'b1, 1'b1);
        send_bit(1'b1);
        check("par_good_vcnt", 32'(vcnt), 32'(v0 + 1));
        check("par_good_data", 32'(vq.pop_front()), 32'h07);
        check("par_good_perr", 32'(pcnt), 32'(f0 + 1));
`else
        f0 = 0;
        check("noparity_perr", 32'(pcnt), 32'(f0));
`endif

        // Reset asserted mid-DATA
        v0 = vcnt;
        f0 = fcnt;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_data", 32'(data), 32'h00);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_ferr", 32'(frame_err), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        check("mid_rst_vcnt", 32'(vcnt), 32'(v0));
        check("mid_rst_fcnt", 32'(fcnt), 32'(f0));
        check("mid_rst_idle", 32'(busy), 32'h0);
        check("valid_ferr_excl", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver for 8N1 frames at a fixed baud rate set by a clocks-per-bit count. It is the receive-side counterpart of the baud-rate generation path and uses the same 100 MHz system clock with 9600 baud default timing. It recovers bit timing from the start-bit falling edge, samples each bit at mid-period, and presents each byte with a one-cycle valid strobe plus error flags.

## Interface
- `CLKS_PER_BIT`, default 10416: system clocks per bit (100 MHz / 9600); legal range ≥ 4.
- `HALF`, default `CLKS_PER_BIT/2` (integer divide): clocks from start-edge detection to the start-bit mid-point.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, asynchronous to `clk`; idle high.
- `data`  out  8  last received byte, LSB first on the wire.
- `valid`  out  1  one-cycle pulse: `data` updated with a good frame.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (see Configuration).
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. The synchronized signal is `rx_s`.
- The bit counter width is `$clog2(CLKS_PER_BIT)`. The bit index is 3 bits. A shift register fills LSB first: each new bit enters at bit 7 and shifts right.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- **IDLE**: when `rx_s`=0, go to START with cnt=0.
- **START**: increment cnt until cnt=HALF-1. At that point:
  - if `rx_s`=0, go to DATA with cnt=0 and idx=0;
  - otherwise it is a glitch; return to IDLE with no flags.
- **DATA**: increment cnt until cnt=CLKS_PER_BIT-1, then sample `rx_s` into the shift register and reset cnt. After idx=7 is sampled, go to PARITY (macro) or STOP.
- **PARITY**: wait one bit period the same way, then sample and store the parity bit.
- **STOP**: wait one bit period, then sample.
  - `rx_s`=1: load `data` from the shift register. Pulse `valid`, unless there is a parity mismatch; in that case pulse `parity_err` instead. Go to IDLE.
  - `rx_s`=0: load `data` anyway and pulse `frame_err`. `parity_err` also pulses if parity mismatched; `valid` stays low. Go to WAIT_HIGH.
- **WAIT_HIGH**: stay until `rx_s`=1, then go to IDLE. A break condition therefore produces exactly one `frame_err`.
- Reset asserted mid-frame: return to IDLE immediately. The partial byte is discarded and no pulse is emitted.
- `valid`, `frame_err` and `parity_err` are never high for more than one cycle. `valid` and `frame_err` are mutually exclusive.

## Timing
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, FSM=IDLE.
- Let edge e be the clock edge at which the start-bit low is first captured into the synchronizer.
  - The FSM enters START at e+2.
  - The start bit is checked at e+2+HALF.
  - Data bit k is sampled at e+2+HALF+(k+1)·CLKS_PER_BIT.
  - The stop bit is sampled, and the output pulses are registered, at e+2+HALF+9·CLKS_PER_BIT. Add one CLKS_PER_BIT when parity is enabled.
- `data` changes only on the edge that registers a stop-bit sample. It holds its value otherwise.
- `busy` goes high at e+2. It goes low on the edge that enters IDLE.
- The FSM returns to IDLE at the stop-bit mid-point, so back-to-back frames with zero idle time are received correctly.

## Configuration
- `UART_RX_PARITY_EN`:
  - **Defined**: frames are 8E1. The PARITY state exists. `parity_err` pulses when the XOR of the 8 data bits and the received parity bit is 1.
  - **Undefined**: frames are 8N1. There is no PARITY state, and `parity_err` is tied to 0.
- The port list is identical in both builds.

## Test plan
- Use CLKS_PER_BIT=16 for all scenarios.
- Reset is held low, then released with `rx`=1: all outputs are 0, `busy`=0, and nothing changes for 200 cycles.
- Send byte 0xA5 (8N1) → one `valid` pulse with `data`=0xA5, exactly 2+8+9·16 cycles after the start edge. `frame_err`=0.
- Send 0x00, 0xFF and 0x3C back-to-back with no idle bits → three `valid` pulses, in order, with the correct bytes.
- Send a 3-cycle low glitch on idle `rx` → no pulses, and `busy` returns to 0 within HALF+3 cycles.
- Send 0x55 with the stop bit 0, then hold `rx` low for 100 cycles → exactly one `frame_err` and no `valid`. A following 0x12 frame is then received correctly.
- With `UART_RX_PARITY_EN` defined, send 0x07 with parity bit 0 → `parity_err` pulses and `valid` stays 0. With parity bit 1 → `valid` pulses and `data`=0x07.
- Assert reset mid-DATA → outputs return to their reset values immediately and no pulse is emitted.
